// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
//   Bytes pushed through wr_en/wr_data are queued in a 2**DEPTH_W entry FIFO
//   and sent LSB-first on tx, one bit every DIV_RATE clocks.
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-low
//   wr_en     push request, wr_data is the byte pushed
//   full      FIFO holds 2**DEPTH_W entries
//   empty     FIFO holds 0 entries
//   count     FIFO occupancy
//   overflow  sticky: a push was dropped because the FIFO was full
//   tx_busy   transmitter is not idle
//   tx_end    one-cycle pulse on the last cycle of each stop bit
//   tx        serial line, idle high
module uart_tx_fifo #(
    parameter int DIV_RATE = 260,
    parameter int DEPTH_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_W:0]   count,
    output logic               overflow,
    output logic               tx_busy,
    output logic               tx_end,
    output logic               tx
);
    localparam int DEPTH = 1 << DEPTH_W;
    localparam int DIV_W = $clog2(DIV_RATE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 tx_end_q, tx_end_d;
    logic                 busy_q, busy_d;
    logic [DEPTH_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           mem_q [DEPTH];

    logic bit_end, pop, push;

    always_comb begin
        bit_end = (div_q == DIV_LAST);
        // The head byte leaves the FIFO only on entry to START.
        pop  = !empty_q && ((state_q == IDLE) || (state_q == STOP && bit_end));
        // A full FIFO still accepts a write in the same cycle as a pop.
        push = wr_en && (!full_q || pop);

        wr_ptr_d = wr_ptr_q + DEPTH_W'(push);
        rd_ptr_d = rd_ptr_q + DEPTH_W'(pop);
        count_d  = count_q + (DEPTH_W+1)'(push) - (DEPTH_W+1)'(pop);
        full_d   = (count_d == (DEPTH_W+1)'(DEPTH));
        empty_d  = (count_d == '0);
        ovf_d    = ovf_q | (wr_en && full_q && !pop);

        state_d = state_q;
        div_d   = bit_end ? '0 : div_q + DIV_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                div_d = '0;
                tx_d  = 1'b1;
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Shift so the bit on the line is always shift_q[0].
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (pop) begin
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered pulse: high while the stop bit sits in its last divider count.
        tx_end_d = (state_d == STOP) && (div_d == DIV_LAST);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            tx_end_q <= 1'b0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            tx_end_q <= tx_end_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (reset && push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign tx_busy  = busy_q;
    assign tx_end   = tx_end_q;
    assign tx       = tx_q;
endmodule
